// File: rtl/csd_digit_scheduler_pkg.sv
// Shared types and constants for the CSD digit scheduler and its converter.
package csd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } csd_state_t;

    localparam int unsigned NDIG = 10;
    localparam int unsigned NCSD = 9;
    localparam int unsigned POSW = 4;

    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_NEG  = 2'b11;
    localparam logic [1:0] DIG_ZERO = 2'b00;

endpackage

// File: rtl/csd_digit_scheduler_csd_out.sv
// Signed-digit to canonical-signed-digit converter (fixed 10 in / 9 out digits).
// Values beyond the 9-digit CSD range (|v| > 341) keep only their low 9 digits.
module CSD_out (
    input  logic [19:0] x,
    output logic [8:0]  mag,
    output logic [8:0]  sgn
);
    import csd_sched_pkg::*;

    logic [9:0] v;
    logic [8:0] th;

    always_comb begin
        v = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            case (x[2*i +: 2])
                DIG_POS: v = v + (10'd1 << i);
                DIG_NEG: v = v - (10'd1 << i);
                default: v = v;
            endcase
        end
        // th is bits [9:1] of 3*v, computed as v + (v >> 1); NAF digits follow from it.
        th  = v[8:0] + v[9:1];
        mag = th ^ v[9:1];
        sgn = ~th & v[9:1];
    end

endmodule

// File: rtl/csd_digit_scheduler.sv
// Accepts one signed-digit coefficient, converts it to CSD, then streams the
// nonzero digits lowest position first, one per dig_valid/dig_ready beat.
module csd_digit_scheduler #(
    parameter int unsigned NDIG      = csd_sched_pkg::NDIG,
    parameter int unsigned NCSD      = csd_sched_pkg::NCSD,
    parameter int unsigned POSW      = csd_sched_pkg::POSW,
    parameter bit          ZERO_BEAT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*NDIG-1:0] in_x,
    input  logic              flush,
    output logic              dig_valid,
    input  logic              dig_ready,
    output logic [POSW-1:0]   dig_pos,
    output logic              dig_neg,
    output logic              dig_last,
    output logic              dig_zero,
    output logic [POSW-1:0]   nz_cnt,
    output logic              busy
);
    import csd_sched_pkg::*;

    csd_state_t        state_q, state_d;
    logic [2*NDIG-1:0] x_q, x_d;
    logic [NCSD-1:0]   mag_q, mag_d;
    logic [NCSD-1:0]   sgn_q, sgn_d;
    logic [POSW-1:0]   nz_q, nz_d;
    logic [NCSD-1:0]   csd_mag, csd_sgn;
    logic [POSW-1:0]   pos;
    logic              emit;

    function automatic logic [POSW-1:0] lsb_index(input logic [NCSD-1:0] v);
        lsb_index = '0;
        for (int unsigned i = NCSD; i > 0; i--) begin
            if (v[i-1]) lsb_index = POSW'(i - 1);
        end
    endfunction

    function automatic logic [POSW-1:0] popcount(input logic [NCSD-1:0] v);
        popcount = '0;
        for (int unsigned i = 0; i < NCSD; i++) begin
            popcount = popcount + POSW'(v[i]);
        end
    endfunction

    CSD_out u_csd_out (
        .x   (x_q),
        .mag (csd_mag),
        .sgn (csd_sgn)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        mag_d   = mag_q;
        sgn_d   = sgn_q;
        nz_d    = nz_q;

        emit      = (state_q == EMIT);
        pos       = lsb_index(mag_q);
        in_ready  = (state_q == IDLE) && !flush;
        busy      = (state_q != IDLE);
        dig_valid = emit;
        dig_zero  = emit && (mag_q == '0);
        dig_pos   = emit ? pos : '0;
        dig_neg   = emit && sgn_q[pos];
        dig_last  = emit && ((mag_q == '0) ||
                             ((mag_q & (mag_q - NCSD'(1))) == '0));

        if (flush) begin
            state_d = IDLE;
            mag_d   = '0;
            sgn_d   = '0;
            nz_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_d     = in_x;
                        state_d = CONV;
                    end
                end
                CONV: begin
                    mag_d   = csd_mag;
                    sgn_d   = csd_sgn;
                    nz_d    = popcount(csd_mag);
                    state_d = ((csd_mag == '0) && !ZERO_BEAT) ? IDLE : EMIT;
                end
                EMIT: begin
                    if (dig_ready) begin
                        mag_d[pos] = 1'b0;
                        if (dig_last) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            mag_q   <= '0;
            sgn_q   <= '0;
            nz_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            mag_q   <= mag_d;
            sgn_q   <= sgn_d;
            nz_q    <= nz_d;
        end
    end

    assign nz_cnt = nz_q;

endmodule
